pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, address/data width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-003 Parameter RESET_ADDR, default 0, instruction address loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 next_target  input  WORD_SIZE  candidate address or jump/call destination.
REQ-007 cand_write  input  1  store next_target into the candidate register selected by pc_source.
REQ-008 pvs_write  input  1  commit new inst_addr per pc_source.
REQ-009 pc_source  input  3  0=SEQ, 1=OFFSET, 2=JUMP, 3=CALL, 4=RET, 5-7 reserved.
REQ-010 clear_err  input  1  clears sticky error flags.
REQ-011 inst_addr  output  WORD_SIZE  current instruction address (registered).
REQ-012 next_seq_addr  output  WORD_SIZE  stored sequential candidate (registered).
REQ-013 ras_count  output  clog2(RAS_DEPTH)+1  valid stack entries.
REQ-014 ras_empty, ras_full  output  1 each  ras_count==0 / ras_count==RAS_DEPTH.
REQ-015 ras_overflow, ras_underflow  output  1 each  sticky error flags.
REQ-016 busy  output  1  high during the post-reset startup cycle.

Function
REQ-017 Priority per edge: reset > startup cycle > pvs_write > cand_write > clear_err-only; pvs_write and cand_write together: pvs_write acts, cand_write ignored.
REQ-018 First clock edge after reset deasserts is the startup cycle: inst_addr held at RESET_ADDR, busy=1, all write inputs ignored; busy=0 from the following cycle.
REQ-019 cand_write, pc_source=SEQ: next_seq_addr <= next_target.
REQ-020 cand_write, pc_source=OFFSET: internal branch register <= next_target.
REQ-021 cand_write with pc_source 2-7: no state change.
REQ-022 pvs_write SEQ: inst_addr <= next_seq_addr.
REQ-023 pvs_write OFFSET: inst_addr <= branch register.
REQ-024 pvs_write JUMP: inst_addr <= next_target; stack unchanged.
REQ-025 pvs_write CALL: inst_addr <= next_target; push next_seq_addr onto stack; ras_count +1.
REQ-026 CALL when full: push overwrites oldest entry (circular), ras_count stays RAS_DEPTH, ras_overflow <= 1.
REQ-027 pvs_write RET, stack non-empty: inst_addr <= top entry; pop; ras_count -1.
REQ-028 RET when empty: inst_addr <= next_seq_addr, ras_count stays 0, ras_underflow <= 1.
REQ-029 pvs_write with pc_source 5-7: no state change.
REQ-030 Stack pointer wraps modulo RAS_DEPTH; an entry pushed after N overflows is popped before older entries (LIFO preserved on the surviving RAS_DEPTH entries).
REQ-031 clear_err clears both sticky flags unless the same edge sets one; setting wins.
REQ-032 All outputs are registered or decode registered state only; no combinational input-to-output path.
REQ-033 Address arithmetic is WORD_SIZE-bit; block performs no increment itself (the datapath supplies all addresses).

Reset
REQ-034 While reset=1 on an edge: inst_addr=RESET_ADDR, next_seq_addr=RESET_ADDR, branch register=0, ras_count=0, stack pointer=0, ras_overflow=0, ras_underflow=0, busy=0; stack contents need not clear.
REQ-035 Reset asserted mid-operation (any state, any concurrent write) takes effect on that edge and discards the write; the startup cycle follows deassertion.

Verification
REQ-036 Reset 2 cycles, deassert, pvs_write JUMP next_target=0x0040 on the first edge -> busy=1, inst_addr=0x0000; same on second edge -> inst_addr=0x0040.
REQ-037 cand_write SEQ 0x0011, cand_write OFFSET 0x0020, pvs_write OFFSET -> inst_addr=0x0020, next_seq_addr=0x0011; then pvs_write SEQ -> inst_addr=0x0011.
REQ-038 Set next_seq 0x0101, CALL 0x0200; set next_seq 0x0201, CALL 0x0300; RET -> 0x0201; RET -> 0x0101, ras_empty=1.
REQ-039 RAS_DEPTH=4: five CALLs with return addresses A1..A5 -> ras_overflow=1, ras_full=1; four RETs yield A5,A4,A3,A2; fifth RET -> inst_addr=next_seq_addr, ras_underflow=1.
REQ-040 Underflow set, clear_err 1 cycle -> both flags 0; clear_err coincident with an empty RET -> ras_underflow stays 1.
REQ-041 Three CALLs then reset mid-sequence with pvs_write RET asserted -> inst_addr=RESET_ADDR, ras_count=0, flags 0, pop discarded.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Instruction-address register with sequential/branch candidate registers and
// a circular return-address stack that overwrites its oldest entry when full.
module pc_stack_unit #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          RAS_DEPTH  = 4,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_SIZE-1:0]         next_target,
  input  logic                         cand_write,
  input  logic                         pvs_write,
  input  logic [2:0]                   pc_source,
  input  logic                         clear_err,
  output logic [WORD_SIZE-1:0]         inst_addr,
  output logic [WORD_SIZE-1:0]         next_seq_addr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         busy
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_OFFSET = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_CALL   = 3'd3;
  localparam logic [2:0] SRC_RET    = 3'd4;

  typedef enum logic {
    ST_START = 1'b0,
    ST_RUN   = 1'b1
  } phase_t;

  phase_t                 phase;
  logic [WORD_SIZE-1:0]   branch_addr;
  logic [PTR_W-1:0]       sp;
  logic [WORD_SIZE-1:0]   ras_mem [RAS_DEPTH];

  logic                   do_pvs;
  logic                   do_cand;
  logic                   do_clear;
  logic                   is_call;
  logic                   is_ret;
  logic                   stack_full;
  logic                   stack_empty;
  logic                   set_ovf;
  logic                   set_unf;
  logic [CNT_W-1:0]       cnt_next;
  logic [PTR_W-1:0]       top_idx;

  // Decode of the current edge's action; writes are gated during startup.
  always_comb begin
    do_pvs      = 1'b0;
    do_cand     = 1'b0;
    do_clear    = 1'b0;
    is_call     = 1'b0;
    is_ret      = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    stack_full  = (ras_count == CNT_W'(RAS_DEPTH));
    stack_empty = (ras_count == '0);
    top_idx     = sp - PTR_W'(1);
    cnt_next    = ras_count;

    if (phase == ST_RUN) begin
      do_pvs   = pvs_write;
      do_cand  = cand_write & ~pvs_write;
      do_clear = clear_err;
    end

    is_call = do_pvs && (pc_source == SRC_CALL);
    is_ret  = do_pvs && (pc_source == SRC_RET);
    set_ovf = is_call & stack_full;
    set_unf = is_ret & stack_empty;

    if (is_call && !stack_full) begin
      cnt_next = ras_count + CNT_W'(1);
    end else if (is_ret && !stack_empty) begin
      cnt_next = ras_count - CNT_W'(1);
    end
  end

  // All architectural state, including the startup phase tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase         <= ST_START;
      inst_addr     <= RESET_ADDR;
      next_seq_addr <= RESET_ADDR;
      branch_addr   <= '0;
      sp            <= '0;
      ras_count     <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      phase         <= ST_RUN;
      busy          <= (phase == ST_START);
      ras_count     <= cnt_next;
      ras_empty     <= (cnt_next == '0);
      ras_full      <= (cnt_next == CNT_W'(RAS_DEPTH));
      ras_overflow  <= set_ovf | (ras_overflow & ~do_clear);
      ras_underflow <= set_unf | (ras_underflow & ~do_clear);

      if (do_cand) begin
        case (pc_source)
          SRC_SEQ:    next_seq_addr <= next_target;
          SRC_OFFSET: branch_addr   <= next_target;
          default:    ;
        endcase
      end

      if (do_pvs) begin
        case (pc_source)
          SRC_SEQ:    inst_addr <= next_seq_addr;
          SRC_OFFSET: inst_addr <= branch_addr;
          SRC_JUMP:   inst_addr <= next_target;
          SRC_CALL: begin
            // When full, sp already points at the oldest slot, so it is overwritten.
            inst_addr   <= next_target;
            ras_mem[sp] <= next_seq_addr;
            sp          <= sp + PTR_W'(1);
          end
          SRC_RET: begin
            if (!stack_empty) begin
              inst_addr <= ras_mem[top_idx];
              sp        <= top_idx;
            end else begin
              inst_addr <= next_seq_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  next_target;
  logic          cand_write;
  logic          pvs_write;
  logic [2:0]    pc_source;
  logic          clear_err;
  logic [W-1:0]  inst_addr;
  logic [W-1:0]  next_seq_addr;
  logic [2:0]    ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_overflow;
  logic          ras_underflow;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] m_inst, m_seq, m_br;
  logic [W-1:0] m_stack[$];
  logic         m_ovf, m_unf, m_busy, m_start;

  always #5 clk = ~clk;

  pc_stack_unit #(.WORD_SIZE(W), .RAS_DEPTH(D), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .next_target(next_target),
    .cand_write(cand_write), .pvs_write(pvs_write), .pc_source(pc_source),
    .clear_err(clear_err), .inst_addr(inst_addr), .next_seq_addr(next_seq_addr),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [W-1:0] nt, input logic cw,
                            input logic pw, input logic [2:0] src, input logic ce);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (r) begin
      m_inst = '0; m_seq = '0; m_br = '0;
      m_stack.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0; m_start = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
      m_busy  = 1'b1;
    end else begin
      m_busy = 1'b0;
      if (pw) begin
        case (src)
          3'd0: m_inst = m_seq;
          3'd1: m_inst = m_br;
          3'd2: m_inst = nt;
          3'd3: begin
            if (m_stack.size() == D) begin
              void'(m_stack.pop_front());
              so = 1'b1;
            end
            m_stack.push_back(m_seq);
            m_inst = nt;
          end
          3'd4: begin
            if (m_stack.size() > 0) m_inst = m_stack.pop_back();
            else begin
              m_inst = m_seq;
              su = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (cw) begin
        if (src == 3'd0) m_seq = nt;
        else if (src == 3'd1) m_br = nt;
      end
      if (so) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (su) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_stack.size();
    check("inst_addr", 32'(inst_addr), 32'(m_inst));
    check("next_seq_addr", 32'(next_seq_addr), 32'(m_seq));
    check("ras_count", 32'(ras_count), 32'(n));
    check("ras_empty", 32'(ras_empty), 32'(n == 0));
    check("ras_full", 32'(ras_full), 32'(n == D));
    check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic step(input logic r, input logic [W-1:0] nt, input logic cw,
                      input logic pw, input logic [2:0] src, input logic ce);
    @(negedge clk);
    reset = r; next_target = nt; cand_write = cw;
    pvs_write = pw; pc_source = src; clear_err = ce;
    @(posedge clk);
    model_edge(r, nt, cw, pw, src, ce);
    #1;
    compare_all();
  endtask

  task automatic set_seq(input logic [W-1:0] a);
    step(1'b0, a, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; next_target = '0; cand_write = 1'b0;
    pvs_write = 1'b0; pc_source = 3'd0; clear_err = 1'b0;
    m_inst = '0; m_seq = '0; m_br = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0; m_start = 1'b0;

    // Reset and startup cycle
    step(1'b1, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    step(1'b0, 16'h0040, 1'b0, 1'b1, 3'd2, 1'b0);
    check("startup_busy", 32'(busy), 32'd1);
    check("startup_hold", 32'(inst_addr), 32'h0000);
    step(1'b0, 16'h0040, 1'b0, 1'b1, 3'd2, 1'b0);
    check("jump_addr", 32'(inst_addr), 32'h0040);
    check("busy_low", 32'(busy), 32'd0);

    // Candidate registers
    set_seq(16'h0011);
    step(1'b0, 16'h0020, 1'b1, 1'b0, 3'd1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0);
    check("offset_addr", 32'(inst_addr), 32'h0020);
    check("seq_hold", 32'(next_seq_addr), 32'h0011);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0);
    check("seq_addr", 32'(inst_addr), 32'h0011);

    // Nested call / return
    set_seq(16'h0101);
    step(1'b0, 16'h0200, 1'b0, 1'b1, 3'd3, 1'b0);
    set_seq(16'h0201);
    step(1'b0, 16'h0300, 1'b0, 1'b1, 3'd3, 1'b0);
    check("call_addr", 32'(inst_addr), 32'h0300);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
    check("ret1", 32'(inst_addr), 32'h0201);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
    check("ret2", 32'(inst_addr), 32'h0101);
    check("ret2_empty", 32'(ras_empty), 32'd1);

    // Overflow and underflow
    for (int i = 1; i <= 5; i++) begin
      set_seq(16'(16'h1000 + i));
      step(1'b0, 16'(16'h2000 + i), 1'b0, 1'b1, 3'd3, 1'b0);
    end
    check("ovf_flag", 32'(ras_overflow), 32'd1);
    check("ovf_full", 32'(ras_full), 32'd1);
    set_seq(16'h0ABC);
    for (int i = 5; i >= 2; i--) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
      check("ovf_ret", 32'(inst_addr), 32'(16'h1000 + i));
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
    check("unf_addr", 32'(inst_addr), 32'h0ABC);
    check("unf_flag", 32'(ras_underflow), 32'd1);

    // Flag clearing
    step(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1);
    check("clr_ovf", 32'(ras_overflow), 32'd0);
    check("clr_unf", 32'(ras_underflow), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b1);
    check("set_wins", 32'(ras_underflow), 32'd1);

    // Reset mid-sequence discards a pending pop
    for (int i = 0; i < 3; i++) step(1'b0, 16'(16'h3000 + i), 1'b0, 1'b1, 3'd3, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
    check("mid_rst_addr", 32'(inst_addr), 32'h0000);
    check("mid_rst_cnt", 32'(ras_count), 32'd0);
    check("mid_rst_unf", 32'(ras_underflow), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b0);
    check("mid_rst_busy", 32'(busy), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), 16'($urandom),
           1'($urandom), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
